// File: rtl/scan_sel_gen_pkg.sv
// Shared types and constants for the digit scanner: FSM state encoding,
// digit geometry and the window-counter width helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int NDIG    = 4;
    localparam int DIG_W   = 4;
    localparam int FRAME_W = NDIG * DIG_W;

    // Width needed to hold the longer of the two window lengths.
    function automatic int cnt_width(input int div, input int blank);
        int m;
        m = (div > blank) ? div : blank;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_tick_cnt.sv
// Loadable down-counter with a terminal-count flag; times both the
// blanking and lit windows of each digit slot.
module scan_tick_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/scan_sel_gen.sv
// Time-multiplexed 4-digit scanner with blanking gap and frame-atomic
// update of the displayed word through a shadow register.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DIV       = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               wr_valid,
    input  logic [FRAME_W-1:0] wr_data,
    output logic               wr_ready,
    output logic [1:0]         sel,
    output logic               en,
    output logic [DIG_W-1:0]   dig,
    output logic               frame_start
);

    localparam int CW = cnt_width(DIV, BLANK_CYC);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DIV_LD   = CW'(DIV - 1);

    scan_state_t        state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               fs_q, fs_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic               pending_q, pending_d;

    logic               cnt_load;
    logic [CW-1:0]      cnt_val;
    logic               cnt_dec;
    logic               cnt_tc;
    logic               frame_end;
    logic               accept;
    logic               apply;

    scan_tick_cnt #(.W(CW)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // Scan sequencing: the counter is reloaded on every state change, so
    // each window is timed from its first cycle.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        en_d     = 1'b0;
        fs_d     = 1'b0;
        cnt_load = 1'b1;
        cnt_val  = {CW{1'b0}};
        cnt_dec  = 1'b0;
        if (!run) begin
            state_d = IDLE;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    sel_d   = 2'd0;
                    fs_d    = 1'b1;
                    cnt_val = BLANK_LD;
                end
                BLANK: begin
                    if (cnt_tc) begin
                        state_d = ON;
                        en_d    = 1'b1;
                        cnt_val = DIV_LD;
                    end else begin
                        cnt_load = 1'b0;
                        cnt_dec  = 1'b1;
                    end
                end
                ON: begin
                    if (cnt_tc) begin
                        state_d = BLANK;
                        sel_d   = sel_q + 2'd1;
                        fs_d    = (sel_q == 2'd3);
                        cnt_val = BLANK_LD;
                    end else begin
                        en_d     = 1'b1;
                        cnt_load = 1'b0;
                        cnt_dec  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    assign frame_end = (state_q == ON) && cnt_tc && (sel_q == 2'd3);
    assign accept    = wr_valid && !pending_q;
    // Only a word already pending before this edge may be applied, so an
    // accept coinciding with a boundary waits for the next one.
    assign apply     = pending_q && (frame_end || (state_q == IDLE));

    // Shadow/active word handling.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (accept) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end else if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            en_q      <= 1'b0;
            fs_q      <= 1'b0;
            active_q  <= {FRAME_W{1'b0}};
            shadow_q  <= {FRAME_W{1'b0}};
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            fs_q      <= fs_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign sel         = sel_q;
    assign en          = en_q;
    assign frame_start = fs_q;
    assign wr_ready    = !pending_q;
    assign dig         = active_q[DIG_W*sel_q +: DIG_W];

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen against a slot/frame-position model.
module tb_scan_sel_gen;

    localparam int DIV = 8;
    localparam int B   = 2;
    localparam int P   = B + DIV;
    localparam int F   = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        wr_ready;
    logic [1:0]  sel;
    logic        en;
    logic [3:0]  dig;
    logic        frame_start;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: idle flag, position k within the frame, and the word registers.
    bit          m_idle = 1'b1;
    int          m_k = 0;
    bit          m_pend = 1'b0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_active = 16'h0000;

    scan_sel_gen #(.DIV(DIV), .BLANK_CYC(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .sel         (sel),
        .en          (en),
        .dig         (dig),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic int m_sel();
        return m_idle ? 0 : (m_k / P) % 4;
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [1:0] s;
        logic       e;
        logic       f;
        s = 2'(m_sel());
        e = !m_idle && ((m_k % P) >= B);
        f = !m_idle && (m_k == 0);
        return {s, e, m_active[4*s +: 4], !m_pend, f};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {sel, en, dig, wr_ready, frame_start};
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_k = 0; m_pend = 1'b0;
        m_shadow = 16'h0000; m_active = 16'h0000;
    endtask

    // One clock edge: advance the model with the inputs seen at that edge.
    task automatic step();
        bit app;
        bit acc;
        @(posedge clk);
        app = m_pend && (m_idle || (m_k == F - 1));
        acc = wr_valid && !m_pend;
        if (acc) begin
            m_shadow = wr_data;
            m_pend = 1'b1;
        end else if (app) begin
            m_active = m_shadow;
            m_pend = 1'b0;
        end
        if (!run) begin
            m_idle = 1'b1; m_k = 0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_k = 0;
        end else begin
            m_k = (m_k + 1) % F;
        end
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (obs_vec() !== 9'b00_0_0000_1_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs_vec(), 9'b00_0_0000_1_0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== 9'b00_0_0000_1_0) begin
                n_fail++;
                $display("FAIL idle_hold cyc %0d: got %b want %b", i, obs_vec(), 9'b00_0_0000_1_0);
            end
        end
    endtask

    task automatic test_basic_scan();
        int fs_first = -1;
        int fs_second = -1;
        int en_first = -1;
        int en_count = 0;
        wr_valid = 1'b1; wr_data = 16'h4321;
        step();
        wr_valid = 1'b0; run = 1'b1;
        for (int i = 1; i <= 41; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_scan cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (frame_start && fs_first < 0) fs_first = i;
            else if (frame_start && fs_second < 0) fs_second = i;
            if (en && en_first < 0) en_first = i;
            if (en && i <= 40) en_count++;
            if (i == 3 || i == 13 || i == 23 || i == 33) begin
                n_chk++;
                if (dig !== 4'((i / 10) + 1)) begin
                    n_fail++;
                    $display("FAIL basic_dig cyc %0d: got %h want %h", i, dig, 4'((i / 10) + 1));
                end
            end
        end
        n_chk++;
        if (fs_first != 1 || en_first != 3) begin
            n_fail++;
            $display("FAIL basic_latency: fs at %0d en at %0d want 1 and 3", fs_first, en_first);
        end
        n_chk++;
        if (fs_second - fs_first != 40 || en_count != 32) begin
            n_fail++;
            $display("FAIL basic_period: period %0d en cycles %0d want 40 and 32", fs_second - fs_first, en_count);
        end
    endtask

    task automatic test_frame_update();
        int guard = 0;
        while (m_sel() != 1 && guard < 100) begin
            step(); guard++;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL update_pre cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
            end
        end
        wr_valid = 1'b1; wr_data = 16'hABCD;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL frame_update cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
            end
            if (m_k == P + B && m_active == 16'hABCD) begin
                n_chk++;
                if (dig !== 4'hC) begin
                    n_fail++;
                    $display("FAIL update_new_dig: got %h want C", dig);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        wr_valid = 1'b1; wr_data = 16'h1111;
        step();
        wr_data = 16'h2222;
        for (int i = 0; i < 2 * F + 5; i++) begin
            step();
            if (!m_pend && m_shadow == 16'h2222) wr_valid = 1'b0;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_pressure cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_stop();
        int guard = 0;
        wr_valid = 1'b1; wr_data = 16'h9876;
        step();
        wr_valid = 1'b0;
        while (!(m_sel() == 2 && exp_vec()[6]) && guard < 100) begin
            step(); guard++;
        end
        n_chk++;
        if (!(sel === 2'd2 && en === 1'b1)) begin
            n_fail++;
            $display("FAIL stop_setup: sel %0d en %b want 2 and 1", sel, en);
        end
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stop_idle cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_chk++;
        if (dig !== 4'h6 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_apply: dig %h ready %b want 6 and 1", dig, wr_ready);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        run = 1'b1;
        while (!exp_vec()[6] && guard < 50) begin
            step(); guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (en !== 1'b0 || dig !== 4'h0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: en %b dig %h sel %0d want 0 0 0", en, dig, sel);
        end
        model_reset();
        run = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_boundary_collision();
        int guard = 0;
        wr_valid = 1'b1; wr_data = 16'h1234;
        step();
        wr_valid = 1'b0; run = 1'b1;
        while (m_k != F - 1 && guard < 200) begin
            step(); guard++;
        end
        wr_valid = 1'b1; wr_data = 16'hEEEE;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL collision cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i == B) begin
                n_chk++;
                if (dig !== 4'h4) begin
                    n_fail++;
                    $display("FAIL collision_old: got %h want 4", dig);
                end
            end
            if (i == F + B) begin
                n_chk++;
                if (dig !== 4'hE) begin
                    n_fail++;
                    $display("FAIL collision_new: got %h want E", dig);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            run      = ($urandom_range(0, 99) < 97);
            wr_valid = ($urandom_range(0, 9) == 0);
            wr_data  = 16'($urandom);
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_frame_update();
        test_back_pressure();
        test_stop();
        test_reset_mid();
        test_boundary_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
